// File: rtl/main_pkg.sv
// Shared constants for the operand/ALU block: data width, FSM encodings,
// and the one-hot bit positions of the in_sel and out_sel controls.
package main_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    EXEC = 2'b10,
    DONE = 2'b11
  } state_e;

  // in_sel bit positions (one-hot)
  localparam int IN_CLEAR   = 0;
  localparam int IN_LOAD    = 1;
  localparam int IN_PERSIST = 2;

  // out_sel bit positions (one-hot, higher bit wins when several are set)
  localparam int OP_SHL = 0;
  localparam int OP_NOT = 1;
  localparam int OP_XOR = 2;
  localparam int OP_OR  = 3;
  localparam int OP_AND = 4;
  localparam int OP_SUB = 5;
  localparam int OP_ADD = 6;

endpackage

// File: rtl/main_if.sv
// Signal bundle for the operand/ALU block. There is no valid/ready pair:
// the master presents operands and controls while curr_state is LOAD/EXEC,
// and final1/final2/out are a valid result whenever curr_state is DONE.
interface main_if;
  import main_pkg::*;

  logic              on;
  logic [2:0]        in_sel;
  logic [DATA_W-1:0] num1;
  logic [DATA_W-1:0] num2;
  logic [6:0]        out_sel;
  logic [DATA_W-1:0] final1;
  logic [DATA_W-1:0] final2;
  logic [DATA_W-1:0] out;
  logic [1:0]        curr_state;
  logic [1:0]        next_state;

  modport master (
    output on, in_sel, num1, num2, out_sel,
    input  final1, final2, out, curr_state, next_state
  );

  modport slave (
    input  on, in_sel, num1, num2, out_sel,
    output final1, final2, out, curr_state, next_state
  );

endinterface

// File: rtl/main_alu.sv
// Combinational ALU: one-hot operation select resolved highest bit first.
// All results wrap to the data width; carries and shifted-out bits are lost.
module alu_core
  import main_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [6:0]        out_sel,
  output logic [DATA_W-1:0] result
);

  // Priority-ordered operation select; no bit set gives zero.
  always_comb begin
    result = '0;
    if (out_sel[OP_ADD])      result = a + b;
    else if (out_sel[OP_SUB]) result = a - b;
    else if (out_sel[OP_AND]) result = a & b;
    else if (out_sel[OP_OR])  result = a | b;
    else if (out_sel[OP_XOR]) result = a ^ b;
    else if (out_sel[OP_NOT]) result = ~a;
    else if (out_sel[OP_SHL]) result = {a[DATA_W-2:0], 1'b0};
  end

endmodule

// File: rtl/main.sv
// Operand/ALU sequencer: IDLE -> LOAD (capture operands) -> EXEC (register
// ALU result) -> DONE, looping back to LOAD while on stays high. Dropping
// on returns to IDLE from any state; rst aborts everything asynchronously.
module main
  import main_pkg::*;
(
  input  logic              clk,
  input  logic              on,
  input  logic              rst,
  input  logic [2:0]        in_sel,
  input  logic [DATA_W-1:0] num1,
  input  logic [DATA_W-1:0] num2,
  output logic [DATA_W-1:0] final1,
  output logic [DATA_W-1:0] final2,
  input  logic [6:0]        out_sel,
  output logic [DATA_W-1:0] out,
  output logic [1:0]        currState,
  output logic [1:0]        nextState
);

  state_e            state;
  state_e            state_nxt;
  logic [DATA_W-1:0] alu_result;

  assign currState = state;
  assign nextState = state_nxt;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; on low overrides every transition back to IDLE.
  always_comb begin
    state_nxt = IDLE;
    if (on) begin
      case (state)
        IDLE:    state_nxt = LOAD;
        LOAD:    state_nxt = EXEC;
        EXEC:    state_nxt = DONE;
        DONE:    state_nxt = LOAD;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Operand registers: clear beats load; persist and any other code hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      final1 <= '0;
      final2 <= '0;
    end else if (state == LOAD) begin
      if (in_sel[IN_CLEAR]) begin
        final1 <= '0;
        final2 <= '0;
      end else if (in_sel[IN_LOAD]) begin
        final1 <= num1;
        final2 <= num2;
      end else if (in_sel[IN_PERSIST]) begin
        final1 <= final1;
        final2 <= final2;
      end
    end
  end

  alu_core u_alu (
    .a       (final1),
    .b       (final2),
    .out_sel (out_sel),
    .result  (alu_result)
  );

  // Result register, written only on the EXEC edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               out <= '0;
    else if (state == EXEC) out <= alu_result;
  end

endmodule

// File: tb/tb_main.sv
// Bench for main: directed operations push {final1, final2, out} into an
// expected queue; a monitor pops and compares whenever the DUT sits in DONE.
module tb_main;
  import main_pkg::*;

  logic clk = 1'b0;
  logic rst;

  main_if bus();

  main dut (
    .clk       (clk),
    .on        (bus.on),
    .rst       (rst),
    .in_sel    (bus.in_sel),
    .num1      (bus.num1),
    .num2      (bus.num2),
    .final1    (bus.final1),
    .final2    (bus.final2),
    .out_sel   (bus.out_sel),
    .out       (bus.out),
    .currState (bus.curr_state),
    .nextState (bus.next_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [23:0] exp_q[$];   // {final1, final2, out}
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every negedge spent in DONE is one presented result.
  initial begin
    logic [23:0] e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && bus.curr_state == DONE) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_result: out=0x%02h with empty expected queue", bus.out);
        end else begin
          e = exp_q.pop_front();
          check("final1", bus.final1, e[23:16]);
          check("final2", bus.final2, e[15:8]);
          check("out",    bus.out,    e[7:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_state(input logic [1:0] st);
    bit hit = 1'b0;
    for (int i = 0; i < 12 && !hit; i++) begin
      @(negedge clk);
      if (bus.curr_state == st) hit = 1'b1;
    end
    n_vec++;
    if (!hit) begin
      n_err++;
      $display("FAIL wait_state: got state %0d, expected %0d within 12 cycles", bus.curr_state, st);
    end
  endtask

  task automatic run_op(input logic [2:0] is, input logic [7:0] n1, input logic [7:0] n2,
                        input logic [6:0] os, input logic [7:0] e1, input logic [7:0] e2,
                        input logic [7:0] eo);
    wait_state(LOAD);
    bus.in_sel  = is;
    bus.num1    = n1;
    bus.num2    = n2;
    bus.out_sel = os;
    exp_q.push_back({e1, e2, eo});
    @(posedge clk);
    #1;
    check("state_exec", {6'b0, bus.curr_state}, {6'b0, EXEC});
    bus.in_sel = 3'b001;           // ignored outside LOAD
    bus.num1   = 8'hC3;
    bus.num2   = 8'h3C;
    @(posedge clk);
    #1;
    bus.out_sel = 7'b1111111;      // ignored outside EXEC
    @(negedge clk);                // DONE: monitor compares here
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    bus.on = 1'b0;
    bus.in_sel = 3'b000;
    bus.num1 = 8'h00;
    bus.num2 = 8'h00;
    bus.out_sel = 7'b0000000;
    #2 rst = 1'b0;
    #1;
    check("rst_state",  {6'b0, bus.curr_state}, 8'h00);
    check("rst_next",   {6'b0, bus.next_state}, 8'h00);
    check("rst_final1", bus.final1, 8'h00);
    check("rst_final2", bus.final2, 8'h00);
    check("rst_out",    bus.out,    8'h00);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("idle_hold", {6'b0, bus.curr_state}, 8'h00);
    bus.on = 1'b1;
    #1;
    check("idle_next", {6'b0, bus.next_state}, 8'h01);

    // Main function over all operations on A=0x57, B=0x1A.
    run_op(3'b010, 8'h57, 8'h1A, 7'b1000000, 8'h57, 8'h1A, 8'h71);
    run_op(3'b010, 8'h57, 8'h1A, 7'b0100000, 8'h57, 8'h1A, 8'h3D);
    run_op(3'b010, 8'h57, 8'h1A, 7'b0010000, 8'h57, 8'h1A, 8'h12);
    run_op(3'b010, 8'h57, 8'h1A, 7'b0001000, 8'h57, 8'h1A, 8'h5F);
    run_op(3'b010, 8'h57, 8'h1A, 7'b0000100, 8'h57, 8'h1A, 8'h4D);
    run_op(3'b010, 8'h57, 8'h1A, 7'b0000010, 8'h57, 8'h1A, 8'hA8);
    run_op(3'b010, 8'h57, 8'h1A, 7'b0000001, 8'h57, 8'h1A, 8'hAE);
    // Persist holds despite new num inputs; multi-hot and empty selects.
    run_op(3'b100, 8'hFF, 8'hFF, 7'b1000000, 8'h57, 8'h1A, 8'h71);
    run_op(3'b010, 8'h57, 8'h1A, 7'b0110000, 8'h57, 8'h1A, 8'h3D);
    run_op(3'b010, 8'h57, 8'h1A, 7'b0000000, 8'h57, 8'h1A, 8'h00);
    // Clear, load-over-persist with carry-out, code 000 holds, clear-over-load.
    run_op(3'b001, 8'h33, 8'h33, 7'b0001000, 8'h00, 8'h00, 8'h00);
    run_op(3'b110, 8'h80, 8'h80, 7'b1000000, 8'h80, 8'h80, 8'h00);
    run_op(3'b000, 8'h99, 8'h99, 7'b0001000, 8'h80, 8'h80, 8'h80);
    run_op(3'b011, 8'h12, 8'h34, 7'b0000100, 8'h00, 8'h00, 8'h00);
    run_op(3'b010, 8'hFF, 8'h01, 7'b1000000, 8'hFF, 8'h01, 8'h00);
    run_op(3'b010, 8'hFF, 8'h01, 7'b0000010, 8'hFF, 8'h01, 8'h00);
    run_op(3'b010, 8'h57, 8'h1A, 7'b0000010, 8'h57, 8'h1A, 8'hA8);

    // Drop on during EXEC: immediate next-state IDLE, out keeps 0xA8.
    wait_state(LOAD);
    bus.in_sel = 3'b010;
    bus.num1 = 8'h57;
    bus.num2 = 8'h3C;
    bus.out_sel = 7'b0000010;
    @(posedge clk);
    #1;
    check("drop_state_exec", {6'b0, bus.curr_state}, {6'b0, EXEC});
    check("drop_final2", bus.final2, 8'h3C);
    bus.on = 1'b0;
    #1;
    check("drop_next", {6'b0, bus.next_state}, 8'h00);
    @(posedge clk);
    #1;
    check("drop_state", {6'b0, bus.curr_state}, 8'h00);
    check("drop_out", bus.out, 8'hA8);
    @(posedge clk);
    #1;
    check("drop_out_idle", bus.out, 8'hA8);

    // Reset mid-EXEC clears everything without a clock edge.
    @(negedge clk);
    bus.on = 1'b1;
    wait_state(LOAD);
    bus.in_sel = 3'b010;
    bus.num1 = 8'h44;
    bus.num2 = 8'h55;
    bus.out_sel = 7'b1000000;
    @(posedge clk);
    #2;
    check("pre_rst_exec", {6'b0, bus.curr_state}, {6'b0, EXEC});
    rst = 1'b0;
    #1;
    check("mid_rst_state",  {6'b0, bus.curr_state}, 8'h00);
    check("mid_rst_final1", bus.final1, 8'h00);
    check("mid_rst_final2", bus.final2, 8'h00);
    check("mid_rst_out",    bus.out,    8'h00);
    check("mid_rst_next",   {6'b0, bus.next_state}, 8'h01);
    @(negedge clk);
    rst = 1'b1;

    // Resume from IDLE after reset: ADD then wrapping SUB.
    run_op(3'b010, 8'h02, 8'h04, 7'b1000000, 8'h02, 8'h04, 8'h06);
    run_op(3'b010, 8'h02, 8'h04, 7'b0100000, 8'h02, 8'h04, 8'hFE);
    bus.on = 1'b0;
    repeat (3) @(negedge clk);

    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d results never presented, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard time limit in case the DUT stalls in an unexpected way.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded 100000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/main.md
MAIN -- requirements
Module: main

Interface
REQ-001 Port order for positional instantiation SHALL be: clk, on, rst, in_sel, num1, num2, final1, final2, out_sel, out, currState, nextState.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 on  input  1  enable; 0 forces the FSM back to IDLE.
REQ-006 in_sel  input  3  operand-register control, one-hot: bit2 persist, bit1 load, bit0 clear.
REQ-007 num1  input  8  operand A source.
REQ-008 num2  input  8  operand B source.
REQ-009 final1  output  8  registered operand A.
REQ-010 final2  output  8  registered operand B.
REQ-011 out_sel  input  7  operation select, one-hot: bit6 ADD, bit5 SUB, bit4 AND, bit3 OR, bit2 XOR, bit1 NOT A, bit0 SHL A.
REQ-012 out  output  8  registered ALU result.
REQ-013 currState  output  2  current FSM state register.
REQ-014 nextState  output  2  combinational next-state value.

Function
REQ-015 States SHALL be IDLE=2'b00, LOAD=2'b01, EXEC=2'b10, DONE=2'b11.
REQ-016 Transitions: IDLE->LOAD if on, else IDLE; LOAD->EXEC; EXEC->DONE; DONE->LOAD if on.
REQ-017 If on=0 in any state, nextState SHALL be IDLE, overriding REQ-016.
REQ-018 nextState SHALL update combinationally from currState and on; currState <= nextState each rising edge.
REQ-019 Operand registers update only on edges where currState=LOAD.
REQ-020 Update priority: in_sel[0] clears both to 0; else in_sel[1] loads final1<=num1, final2<=num2; else hold (covers persist, 000 and any other code).
REQ-021 out updates only on edges where currState=EXEC, from final1 (A) and final2 (B); otherwise it holds.
REQ-022 ADD=(A+B) mod 256; SUB=(A-B) mod 256 (two's complement wrap); AND/OR/XOR bitwise; NOT A=~A; SHL A={A[6:0],0}; carries, borrows and shifted-out bits are discarded.
REQ-023 Multi-hot out_sel SHALL resolve by priority, highest bit first; out_sel=0 yields out=0.
REQ-024 Latency: operands visible on final1/final2 one edge after entering LOAD; result visible on out one edge after entering EXEC, i.e. 3 edges after leaving IDLE with on=1.
REQ-025 Inputs change only in LOAD/EXEC-sampled cycles matter; in_sel and out_sel are don't-care in other states.

Reset
REQ-026 With rst=0, asynchronously: currState=IDLE, final1=0, final2=0, out=0; nextState follows REQ-016/017 from IDLE.
REQ-027 Reset asserted mid-operation SHALL abort immediately with no partial register update; operation resumes from IDLE after release.

Structure
REQ-028 A shared package SHALL hold the data width (8), the state encodings, and the one-hot in_sel/out_sel bit-position constants.
REQ-029 One combinational sub-module alu_core (A, B, out_sel -> result) SHALL implement REQ-022/023; FSM and registers stay in main.

Verification
REQ-030 rst=0 pulse mid-EXEC -> out, final1, final2 = 0 and currState=00 immediately, without waiting for a clock edge.
REQ-031 on=1, in_sel=010, num1=0x57, num2=0x1A, out_sel=1000000 -> final1=0x57, final2=0x1A, then out=0x71 (113); states 00->01->10->11.
REQ-032 After reset, in_sel=010, num1=0x02, num2=0x04, ADD -> out=0x06; then SUB -> 0xFE (wrap).
REQ-033 A=0x57, B=0x1A, one pass each: AND=0x12, OR=0x5F, XOR=0x4D, NOT A=0xA8, SHL A=0xAE.
REQ-034 in_sel=001 in LOAD -> final1=final2=0; in_sel=100 -> values held though num1/num2 change.
REQ-035 on dropped in EXEC -> nextState=00 immediately, currState=00 next edge, out holds; out_sel=0000000 pass -> out=0.
